// File: rtl/i2c_apb_sched.sv
// i2c_apb_sched: arbitrates two requesters onto one APB-attached I2C core.
// Each granted transaction programs target address and data, starts the core,
// waits for its stop indication (bounded by TIMEOUT), then disables the core
// and reports completion, with err marking a timed-out transaction.
module i2c_apb_sched #(
  parameter int TIMEOUT = 1024,
  parameter int AW      = 8,
  parameter int DW      = 8
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic [1:0]    req,
  input  logic [6:0]    slv_addr0,
  input  logic [6:0]    slv_addr1,
  input  logic [7:0]    wdata0,
  input  logic [7:0]    wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic          err,
  output logic          busy,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic          pready,
  input  logic          stop
);

  // Counter holds 0..TIMEOUT-1 and stops there, so it never wraps.
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_STOP, DONE} state_t;

  state_t        state;
  logic [1:0]    step;
  logic [CW-1:0] cnt;
  logic          err_r;
  logic          last_gnt;
  logic          cur_id;
  logic [6:0]    cur_addr;
  logic [7:0]    cur_data;

  logic          win;
  logic [6:0]    win_addr;
  logic [7:0]    win_data;

  // Register map address for each step of the write sequence.
  function automatic logic [AW-1:0] step_addr(input logic [1:0] s);
    case (s)
      2'd0:    step_addr = AW'(1);
      2'd1:    step_addr = AW'(2);
      default: step_addr = AW'(4);
    endcase
  endfunction

  // Write data for each step: address byte (write direction), data, start, stop.
  function automatic logic [DW-1:0] step_data(input logic [1:0] s,
                                              input logic [6:0] a,
                                              input logic [7:0] d);
    case (s)
      2'd0:    step_data = DW'({a, 1'b0});
      2'd1:    step_data = DW'(d);
      2'd2:    step_data = DW'(8'h80);
      default: step_data = '0;
    endcase
  endfunction

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ~last_gnt;
    end else begin
      win = req[1];
    end
    win_addr = win ? slv_addr1 : slv_addr0;
    win_data = win ? wdata1    : wdata0;
  end

  // Scheduler FSM; every output is registered alongside the state.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= IDLE;
      step     <= 2'd0;
      cnt      <= '0;
      err_r    <= 1'b0;
      last_gnt <= 1'b1;
      cur_id   <= 1'b0;
      gnt      <= 2'b00;
      done     <= 2'b00;
      err      <= 1'b0;
      busy     <= 1'b0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
    end else begin
      gnt  <= 2'b00;
      done <= 2'b00;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            cur_id   <= win;
            last_gnt <= win;
            cur_addr <= win_addr;
            cur_data <= win_data;
            step     <= 2'd0;
            gnt      <= win ? 2'b10 : 2'b01;
            busy     <= 1'b1;
            psel     <= 1'b1;
            penable  <= 1'b0;
            pwrite   <= 1'b1;
            paddr    <= step_addr(2'd0);
            pwdata   <= step_data(2'd0, win_addr, win_data);
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            if (step[1]) begin
              psel    <= 1'b0;
              penable <= 1'b0;
              pwrite  <= 1'b0;
              paddr   <= '0;
              pwdata  <= '0;
              if (step == 2'd2) begin
                cnt   <= '0;
                state <= WAIT_STOP;
              end else begin
                done  <= cur_id ? 2'b10 : 2'b01;
                err   <= err_r;
                state <= DONE;
              end
            end else begin
              // Back-to-back write: psel stays high, penable drops for SETUP.
              step    <= step + 2'd1;
              penable <= 1'b0;
              paddr   <= step_addr(step + 2'd1);
              pwdata  <= step_data(step + 2'd1, cur_addr, cur_data);
              state   <= SETUP;
            end
          end
        end
        WAIT_STOP: begin
          // A stop seen on the final count still counts as success.
          if (stop || (cnt == CNT_LAST)) begin
            err_r   <= ~stop;
            step    <= 2'd3;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= 1'b1;
            paddr   <= step_addr(2'd3);
            pwdata  <= step_data(2'd3, cur_addr, cur_data);
            state   <= SETUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          psel    <= 1'b0;
          penable <= 1'b0;
          pwrite  <= 1'b0;
          paddr   <= '0;
          pwdata  <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_apb_sched.sv
// Scoreboard bench for i2c_apb_sched: stimulus pushes the expected grant,
// APB write and completion events (with cycle gaps where timing matters);
// a monitor pops and compares each event as the DUT produces it.
module tb_i2c_apb_sched;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [6:0] slv_addr0 = 7'h00;
  logic [6:0] slv_addr1 = 7'h00;
  logic [7:0] wdata0 = 8'h00;
  logic [7:0] wdata1 = 8'h00;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       err;
  logic       busy;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic       pready = 1'b0;
  logic       stop = 1'b0;

  i2c_apb_sched #(.TIMEOUT(16), .AW(8), .DW(8)) dut (
    .pclk(pclk), .preset(preset), .req(req),
    .slv_addr0(slv_addr0), .slv_addr1(slv_addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done(done), .err(err), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .stop(stop)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int         kind;   // 0 grant, 1 APB write, 2 done
    logic [7:0] a;
    logic [7:0] b;
    int         gap;    // cycles since previous event, -1 = don't care
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  last_cyc = 0;
  int  wait_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
  endtask

  task automatic push_ev(input int kind, input logic [7:0] a, input logic [7:0] b, input int gap);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_txn(input int id, input logic [6:0] sa, input logic [7:0] wd,
                          input int ggap, input int g1, input int g2, input int g3,
                          input int g4, input logic e);
    logic [7:0] oh;
    oh = (id == 1) ? 8'h02 : 8'h01;
    push_ev(0, oh, 8'h00, ggap);
    push_ev(1, 8'h01, {sa, 1'b0}, g1);
    push_ev(1, 8'h02, wd, g2);
    push_ev(1, 8'h04, 8'h80, g3);
    push_ev(1, 8'h04, 8'h00, g4);
    push_ev(2, oh, {7'd0, e}, 1);
  endtask

  task automatic mon_ev(input int kind, input logic [7:0] a, input logic [7:0] b);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind %0d a=0x%0h b=0x%0h at cycle %0d, want none",
               kind, a, b, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.a == a && e.b == b && (e.gap < 0 || cyc - last_cyc == e.gap))
        n_pass++;
      else
        $display("FAIL event: got kind %0d a=0x%0h b=0x%0h gap %0d, want kind %0d a=0x%0h b=0x%0h gap %0d",
                 kind, a, b, cyc - last_cyc, e.kind, e.a, e.b, e.gap);
    end
    last_cyc = cyc;
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  // APB slave: inserts wait_n wait states in every access.
  initial begin : responder
    int k;
    k = 0;
    forever begin
      @(posedge pclk);
      #1;
      if (psel && penable) begin
        pready = (k == wait_n);
        k++;
      end else begin
        k = 0;
        pready = 1'b0;
      end
    end
  end

  // Monitor: compares every DUT event against the scoreboard queue.
  initial begin : monitor
    logic       hold_prev;
    logic [7:0] hold_a;
    logic [7:0] hold_b;
    hold_prev = 1'b0;
    hold_a = 8'h00;
    hold_b = 8'h00;
    forever begin
      @(negedge pclk);
      if (gnt != 2'b00) mon_ev(0, {6'd0, gnt}, 8'h00);
      if (psel && penable && pready) mon_ev(1, paddr, pwdata);
      if (done != 2'b00) mon_ev(2, {6'd0, done}, {7'd0, err});
      if (psel && penable && hold_prev)
        chk("apb_hold", {16'd0, paddr, pwdata}, {16'd0, hold_a, hold_b});
      hold_prev = psel && penable && !pready;
      hold_a = paddr;
      hold_b = pwdata;
    end
  end

  task automatic wait_gnt();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge pclk);
      if (gnt != 2'b00) break;
    end
    chk("gnt_seen", 32'(n < 50), 32'd1);
  endtask

  // Waits for the enable write, raises stop k_stop cycles later (never if
  // negative), then waits for the done pulse.
  task automatic serve(input int k_stop, output logic [1:0] d);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge pclk);
      if (psel && penable && pready && paddr == 8'h04 && pwdata == 8'h80) break;
    end
    chk("enable_write_seen", 32'(n < 300), 32'd1);
    if (k_stop >= 0) begin
      repeat (k_stop) @(negedge pclk);
      stop = 1'b1;
      @(negedge pclk);
      stop = 1'b0;
    end
    for (n = 0; n < 300; n++) begin
      @(negedge pclk);
      if (done != 2'b00) break;
    end
    chk("done_seen", 32'(n < 300), 32'd1);
    d = done;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no completion, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [1:0] d;
    int n;

    // Reset state
    repeat (3) @(negedge pclk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", 32'(pwdata), 32'd0);
    preset = 1'b0;
    @(negedge pclk);

    // Single request, stop 10 cycles after the enable write
    slv_addr0 = 7'h50; wdata0 = 8'hA5;
    push_txn(0, 7'h50, 8'hA5, -1, 1, 2, 2, 12, 1'b0);
    req = 2'b01;
    @(negedge pclk);
    chk("gnt_latency", 32'(gnt), 32'd1);
    chk("busy_active", 32'(busy), 32'd1);
    serve(10, d);
    req = 2'b00;
    chk("single_done", 32'(d), 32'd1);
    @(negedge pclk);
    chk("busy_after_done", 32'(busy), 32'd0);
    repeat (3) @(negedge pclk);

    // Simultaneous requests after reset: 0,1 then 0,1 (req0 withdrawn in round 2)
    preset = 1'b1;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    slv_addr0 = 7'h12; wdata0 = 8'h34;
    slv_addr1 = 7'h7F; wdata1 = 8'hC3;
    push_txn(0, 7'h12, 8'h34, -1, 1, 2, 2, 7, 1'b0);
    push_txn(1, 7'h7F, 8'hC3,  2, 1, 2, 2, 7, 1'b0);
    req = 2'b11;
    serve(5, d);
    chk("rr1_first", 32'(d), 32'd1);
    req = 2'b10;
    serve(5, d);
    chk("rr1_second", 32'(d), 32'd2);
    req = 2'b00;
    repeat (2) @(negedge pclk);
    push_txn(0, 7'h12, 8'h34, -1, 1, 2, 2, 7, 1'b0);
    push_txn(1, 7'h7F, 8'hC3,  2, 1, 2, 2, 7, 1'b0);
    req = 2'b11;
    wait_gnt();
    req = 2'b10;
    serve(5, d);
    chk("rr2_first", 32'(d), 32'd1);
    serve(5, d);
    chk("rr2_second", 32'(d), 32'd2);
    req = 2'b00;
    repeat (2) @(negedge pclk);

    // Three wait states per access
    wait_n = 3;
    slv_addr1 = 7'h2A; wdata1 = 8'h5C;
    push_txn(1, 7'h2A, 8'h5C, -1, 4, 5, 5, 8, 1'b0);
    req = 2'b10;
    serve(3, d);
    req = 2'b00;
    chk("wait_done", 32'(d), 32'd2);
    wait_n = 0;
    repeat (2) @(negedge pclk);

    // Timeout: stop never asserted
    slv_addr0 = 7'h01; wdata0 = 8'hFF;
    push_txn(0, 7'h01, 8'hFF, -1, 1, 2, 2, 18, 1'b1);
    req = 2'b01;
    serve(-1, d);
    req = 2'b00;
    chk("timeout_done", 32'(d), 32'd1);
    repeat (2) @(negedge pclk);

    // Stop on the final timeout cycle
    slv_addr1 = 7'h33; wdata1 = 8'h00;
    push_txn(1, 7'h33, 8'h00, -1, 1, 2, 2, 18, 1'b0);
    req = 2'b10;
    serve(16, d);
    req = 2'b00;
    chk("coincide_done", 32'(d), 32'd2);
    repeat (2) @(negedge pclk);

    // Reset during the step-1 access
    wait_n = 2;
    slv_addr0 = 7'h11; wdata0 = 8'h22;
    push_ev(0, 8'h01, 8'h00, -1);
    push_ev(1, 8'h01, 8'h22, 3);
    req = 2'b01;
    for (n = 0; n < 50; n++) begin
      @(negedge pclk);
      if (psel && penable && paddr == 8'h02) break;
    end
    chk("step1_access_seen", 32'(n < 50), 32'd1);
    preset = 1'b1;
    @(negedge pclk);
    chk("mid_rst_psel", 32'(psel), 32'd0);
    chk("mid_rst_penable", 32'(penable), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    preset = 1'b0;
    wait_n = 0;
    push_txn(0, 7'h11, 8'h22, -1, 1, 2, 2, 7, 1'b0);
    req = 2'b11;
    serve(5, d);
    req = 2'b00;
    chk("post_rst_first", 32'(d), 32'd1);

    repeat (5) @(negedge pclk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
